// File: rtl/self_test_run_scheduler.sv
// self_test_run_scheduler
// Soak-test sequencer for the NPU self-tester. Each run holds the tester in
// reset for RST_CYCLES, releases it, waits for i_test_done or a watchdog
// expiry, then records the outcome. Keeps pass/fail/timeout tallies
// (saturating) and min/max/total of the reported perf counter.
// Optional build macro SELF_TEST_SCHED_STOP_ON_FAIL_EN: end the sequence at
// the first failing or timed-out run, leaving the tester in reset.
module self_test_run_scheduler #(
    parameter int unsigned RUNW        = 16,
    parameter int unsigned RST_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYC = 2000000,
    parameter int unsigned TOTW        = 48
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_start,
    input  logic [RUNW-1:0]   i_num_runs,
    input  logic              i_test_done,
    input  logic [2:0]        i_test_status,
    input  logic [31:0]       i_perf_counter,
    output logic              o_shim_reset,
    output logic              o_busy,
    output logic              o_done,
    output logic [RUNW-1:0]   o_pass_count,
    output logic [RUNW-1:0]   o_fail_count,
    output logic [RUNW-1:0]   o_timeout_count,
    output logic [31:0]       o_min_cycles,
    output logic [31:0]       o_max_cycles,
    output logic [TOTW-1:0]   o_total_cycles
);

    // Counter widths sized to hold the terminal count (value - 1).
    localparam int unsigned RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int unsigned WDW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYCLES - 1);
    localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT_CYC - 1);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SHIM_RST = 3'd1;
    localparam logic [2:0] ST_RUN      = 3'd2;
    localparam logic [2:0] ST_RECORD   = 3'd3;
    localparam logic [2:0] ST_FIN      = 3'd4;

    localparam logic [2:0] STATUS_SUCCESS = 3'b010;

    logic [2:0]      state_q,     state_d;
    logic [RUNW-1:0] num_runs_q,  num_runs_d;
    logic [RUNW-1:0] runs_done_q, runs_done_d;
    logic [RCW-1:0]  rst_cnt_q,   rst_cnt_d;
    logic [WDW-1:0]  wdog_q,      wdog_d;
    logic            rec_timeout_q, rec_timeout_d;
    logic            rec_pass_q,  rec_pass_d;
    logic [31:0]     rec_perf_q,  rec_perf_d;
    logic [RUNW-1:0] pass_q,      pass_d;
    logic [RUNW-1:0] fail_q,      fail_d;
    logic [RUNW-1:0] tmo_q,       tmo_d;
    logic [31:0]     min_q,       min_d;
    logic [31:0]     max_q,       max_d;
    logic [TOTW-1:0] total_q,     total_d;
    logic            last_run;
    logic            finish_seq;

    function automatic logic [RUNW-1:0] sat_inc(input logic [RUNW-1:0] v);
        return (v == '1) ? v : v + RUNW'(1);
    endfunction

    // Next-state and result-update logic for the run sequencer.
    always_comb begin
        state_d       = state_q;
        num_runs_d    = num_runs_q;
        runs_done_d   = runs_done_q;
        rst_cnt_d     = rst_cnt_q;
        wdog_d        = wdog_q;
        rec_timeout_d = rec_timeout_q;
        rec_pass_d    = rec_pass_q;
        rec_perf_d    = rec_perf_q;
        pass_d        = pass_q;
        fail_d        = fail_q;
        tmo_d         = tmo_q;
        min_d         = min_q;
        max_d         = max_q;
        total_d       = total_q;
        last_run      = 1'b0;
        finish_seq    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    num_runs_d  = i_num_runs;
                    runs_done_d = '0;
                    pass_d      = '0;
                    fail_d      = '0;
                    tmo_d       = '0;
                    min_d       = '1;
                    max_d       = '0;
                    total_d     = '0;
                    rst_cnt_d   = '0;
                    wdog_d      = '0;
                    state_d     = (i_num_runs == '0) ? ST_FIN : ST_SHIM_RST;
                end
            end

            ST_SHIM_RST: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    rst_cnt_d = rst_cnt_q + RCW'(1);
                end
            end

            ST_RUN: begin
                wdog_d = wdog_q + WDW'(1);
                // A done seen on the expiry cycle is still a normal completion.
                if (i_test_done) begin
                    rec_timeout_d = 1'b0;
                    rec_pass_d    = (i_test_status == STATUS_SUCCESS);
                    rec_perf_d    = i_perf_counter;
                    state_d       = ST_RECORD;
                end else if (wdog_q == WD_LAST) begin
                    rec_timeout_d = 1'b1;
                    rec_pass_d    = 1'b0;
                    state_d       = ST_RECORD;
                end
            end

            ST_RECORD: begin
                runs_done_d = runs_done_q + RUNW'(1);
                if (rec_timeout_q) begin
                    fail_d = sat_inc(fail_q);
                    tmo_d  = sat_inc(tmo_q);
                end else begin
                    if (rec_pass_q) begin
                        pass_d = sat_inc(pass_q);
                    end else begin
                        fail_d = sat_inc(fail_q);
                    end
                    if (rec_perf_q < min_q) begin
                        min_d = rec_perf_q;
                    end
                    if (rec_perf_q > max_q) begin
                        max_d = rec_perf_q;
                    end
                    total_d = total_q + TOTW'(rec_perf_q);
                end
                last_run = (runs_done_d == num_runs_q);
`ifdef SELF_TEST_SCHED_STOP_ON_FAIL_EN
                finish_seq = last_run || rec_timeout_q || !rec_pass_q;
`else
                finish_seq = last_run;
`endif
                if (finish_seq) begin
                    state_d = ST_FIN;
                end else begin
                    rst_cnt_d = '0;
                    wdog_d    = '0;
                    state_d   = ST_SHIM_RST;
                end
            end

            ST_FIN: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and result registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            num_runs_q    <= '0;
            runs_done_q   <= '0;
            rst_cnt_q     <= '0;
            wdog_q        <= '0;
            rec_timeout_q <= 1'b0;
            rec_pass_q    <= 1'b0;
            rec_perf_q    <= '0;
            pass_q        <= '0;
            fail_q        <= '0;
            tmo_q         <= '0;
            min_q         <= '1;
            max_q         <= '0;
            total_q       <= '0;
        end else begin
            state_q       <= state_d;
            num_runs_q    <= num_runs_d;
            runs_done_q   <= runs_done_d;
            rst_cnt_q     <= rst_cnt_d;
            wdog_q        <= wdog_d;
            rec_timeout_q <= rec_timeout_d;
            rec_pass_q    <= rec_pass_d;
            rec_perf_q    <= rec_perf_d;
            pass_q        <= pass_d;
            fail_q        <= fail_d;
            tmo_q         <= tmo_d;
            min_q         <= min_d;
            max_q         <= max_d;
            total_q       <= total_d;
        end
    end

    // Tester is released only while a run is actually executing.
    assign o_shim_reset    = (state_q != ST_RUN);
    assign o_busy          = (state_q != ST_IDLE);
    assign o_done          = (state_q == ST_FIN);
    assign o_pass_count    = pass_q;
    assign o_fail_count    = fail_q;
    assign o_timeout_count = tmo_q;
    assign o_min_cycles    = min_q;
    assign o_max_cycles    = max_q;
    assign o_total_cycles  = total_q;

endmodule

// File: tb/tb_self_test_run_scheduler.sv
// tb_self_test_run_scheduler
// Directed bench with a behavioural self-tester responder. Expectations are
// hand-computed; the macro SELF_TEST_SCHED_STOP_ON_FAIL_EN selects the
// stop-on-fail expectations.
module tb_self_test_run_scheduler;

    localparam int unsigned RUNW = 16;
    localparam int unsigned RSTC = 4;
    localparam int unsigned TMO  = 1000;
    localparam int unsigned TOTW = 48;

    logic            clk = 1'b0;
    logic            reset;
    logic            i_start;
    logic [RUNW-1:0] i_num_runs;
    logic            i_test_done;
    logic [2:0]      i_test_status;
    logic [31:0]     i_perf_counter;
    logic            o_shim_reset;
    logic            o_busy;
    logic            o_done;
    logic [RUNW-1:0] o_pass_count;
    logic [RUNW-1:0] o_fail_count;
    logic [RUNW-1:0] o_timeout_count;
    logic [31:0]     o_min_cycles;
    logic [31:0]     o_max_cycles;
    logic [TOTW-1:0] o_total_cycles;

    int unsigned total_n = 0;
    int unsigned bad_n   = 0;

    self_test_run_scheduler #(
        .RUNW(RUNW),
        .RST_CYCLES(RSTC),
        .TIMEOUT_CYC(TMO),
        .TOTW(TOTW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .i_start(i_start),
        .i_num_runs(i_num_runs),
        .i_test_done(i_test_done),
        .i_test_status(i_test_status),
        .i_perf_counter(i_perf_counter),
        .o_shim_reset(o_shim_reset),
        .o_busy(o_busy),
        .o_done(o_done),
        .o_pass_count(o_pass_count),
        .o_fail_count(o_fail_count),
        .o_timeout_count(o_timeout_count),
        .o_min_cycles(o_min_cycles),
        .o_max_cycles(o_max_cycles),
        .o_total_cycles(o_total_cycles)
    );

    always #5 clk = ~clk;

    // Responder: run_len[k] = cycles out of reset before done (0 = never),
    // reported perf = run_len[k], status = run_stat[k]. Also records the
    // length of each released period and the reset gap preceding it.
    int unsigned run_len [8];
    logic [2:0]  run_stat [8];
    int unsigned low_obs [8];
    int unsigned gap_obs [8];
    int unsigned idx;
    int unsigned cyc;
    int unsigned hi;
    int unsigned nxt;
    logic        active;
    logic        tclr;

    assign nxt = active ? cyc + 1 : 1;

    always @(posedge clk) begin
        if (tclr) begin
            idx            <= 0;
            cyc            <= 0;
            hi             <= 0;
            active         <= 1'b0;
            i_test_done    <= 1'b0;
            i_test_status  <= 3'b000;
            i_perf_counter <= 32'd0;
        end else if (o_shim_reset) begin
            i_test_done <= 1'b0;
            if (active) begin
                low_obs[idx] <= cyc;
                idx          <= idx + 1;
                active       <= 1'b0;
                hi           <= 1;
            end else begin
                hi <= hi + 1;
            end
        end else begin
            if (!active) begin
                gap_obs[idx] <= hi;
                active       <= 1'b1;
            end
            cyc <= nxt;
            if (!i_test_done && run_len[idx] != 0 && nxt == run_len[idx]) begin
                i_test_done    <= 1'b1;
                i_test_status  <= run_stat[idx];
                i_perf_counter <= run_len[idx];
            end
        end
    end

    int unsigned done_seen = 0;
    always @(negedge clk) begin
        if (o_done) done_seen <= done_seen + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_n++;
        if (got !== exp) begin
            bad_n++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_res(input string t, input int unsigned p, input int unsigned f,
                           input int unsigned to, input logic [31:0] mn,
                           input logic [31:0] mx, input logic [63:0] tot);
        chk({t, "_pass"},  64'(o_pass_count),    64'(p));
        chk({t, "_fail"},  64'(o_fail_count),    64'(f));
        chk({t, "_tmo"},   64'(o_timeout_count), 64'(to));
        chk({t, "_min"},   64'(o_min_cycles),    64'(mn));
        chk({t, "_max"},   64'(o_max_cycles),    64'(mx));
        chk({t, "_total"}, 64'(o_total_cycles),  tot);
    endtask

    task automatic tester_clear();
        @(negedge clk);
        tclr = 1'b1;
        @(negedge clk);
        tclr = 1'b0;
    endtask

    task automatic start_seq(input int unsigned n);
        @(negedge clk);
        i_start    = 1'b1;
        i_num_runs = RUNW'(n);
        @(negedge clk);
        i_start    = 1'b0;
        i_num_runs = '0;
    endtask

    task automatic wait_idle(input string tag);
        int unsigned k = 0;
        while (o_busy && k < 20000) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 64'(o_busy), 64'd0);
    endtask

    task automatic set_runs(input int unsigned k, input int unsigned len, input logic [2:0] st);
        run_len[k]  = len;
        run_stat[k] = st;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got=running exp=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int unsigned lat;
        int unsigned d0;
        int unsigned k;

        reset      = 1'b1;
        i_start    = 1'b0;
        i_num_runs = '0;
        tclr       = 1'b1;
        for (int i = 0; i < 8; i++) begin
            run_len[i]  = 0;
            run_stat[i] = 3'b010;
        end
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_shim", 64'(o_shim_reset), 64'd1);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_done", 64'(o_done), 64'd0);
        chk_res("rst", 0, 0, 0, 32'hFFFF_FFFF, 32'd0, 64'd0);
        reset = 1'b0;
        tclr  = 1'b0;
        repeat (2) @(negedge clk);

        // T1: three passing runs of 100, start ignored during RUN
        tester_clear();
        for (int i = 0; i < 3; i++) set_runs(i, 100, 3'b010);
        d0 = done_seen;
        start_seq(3);
        chk("t1_busy", 64'(o_busy), 64'd1);
        lat = 1;
        while (o_shim_reset && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("t1_latency", 64'(lat), 64'(1 + RSTC));
        i_start    = 1'b1;
        i_num_runs = 16'd7;
        @(negedge clk);
        i_start    = 1'b0;
        i_num_runs = '0;
        wait_idle("t1_end");
        chk("t1_done_pulses", 64'(done_seen - d0), 64'd1);
        chk("t1_runs", 64'(idx), 64'd3);
        chk_res("t1", 3, 0, 0, 32'd100, 32'd100, 64'd300);

        // T2: perf 50/80/20/60
        tester_clear();
        set_runs(0, 50, 3'b010);
        set_runs(1, 80, 3'b010);
        set_runs(2, 20, 3'b010);
        set_runs(3, 60, 3'b010);
        d0 = done_seen;
        start_seq(4);
        wait_idle("t2_end");
        chk("t2_done_pulses", 64'(done_seen - d0), 64'd1);
        chk_res("t2", 4, 0, 0, 32'd20, 32'd80, 64'd210);

        // T3: first run never completes -> watchdog
        tester_clear();
        set_runs(0, 0, 3'b010);
        set_runs(1, 30, 3'b010);
        d0 = done_seen;
        start_seq(2);
        wait_idle("t3_end");
        chk("t3_done_pulses", 64'(done_seen - d0), 64'd1);
        chk("t3_run1_len", 64'(low_obs[0]), 64'(TMO));
`ifdef SELF_TEST_SCHED_STOP_ON_FAIL_EN
        chk("t3_runs", 64'(idx), 64'd1);
        chk_res("t3", 0, 1, 1, 32'hFFFF_FFFF, 32'd0, 64'd0);
`else
        chk("t3_runs", 64'(idx), 64'd2);
        chk("t3_gap", 64'(gap_obs[1]), 64'(1 + RSTC));
        chk_res("t3", 1, 1, 1, 32'd30, 32'd30, 64'd30);
`endif

        // T4: run 1 fails with status 3'b100
        tester_clear();
        set_runs(0, 40, 3'b100);
        set_runs(1, 40, 3'b010);
        set_runs(2, 40, 3'b010);
        d0 = done_seen;
        start_seq(3);
        wait_idle("t4_end");
        chk("t4_done_pulses", 64'(done_seen - d0), 64'd1);
`ifdef SELF_TEST_SCHED_STOP_ON_FAIL_EN
        chk("t4_runs", 64'(idx), 64'd1);
        chk_res("t4", 0, 1, 0, 32'd40, 32'd40, 64'd40);
`else
        chk("t4_runs", 64'(idx), 64'd3);
        chk_res("t4", 2, 1, 0, 32'd40, 32'd40, 64'd120);
`endif

        // T5: zero runs -> immediate FIN, results cleared, tester never released
        tester_clear();
        d0 = done_seen;
        start_seq(0);
        chk("t5_done_now", 64'(o_done), 64'd1);
        chk("t5_shim", 64'(o_shim_reset), 64'd1);
        wait_idle("t5_end");
        chk("t5_done_pulses", 64'(done_seen - d0), 64'd1);
        chk("t5_released", 64'({idx[3:0], active}), 64'd0);
        chk_res("t5", 0, 0, 0, 32'hFFFF_FFFF, 32'd0, 64'd0);

        // T6: reset during RUN of run 2
        tester_clear();
        for (int i = 0; i < 3; i++) set_runs(i, 100, 3'b010);
        start_seq(3);
        k = 0;
        while ((idx < 1 || !active) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("t6_in_run2", 64'(idx), 64'd1);
        chk("t6_pass_before", 64'(o_pass_count), 64'd1);
        d0 = done_seen;
        reset = 1'b1;
        @(negedge clk);
        chk("t6_shim", 64'(o_shim_reset), 64'd1);
        chk("t6_busy", 64'(o_busy), 64'd0);
        chk("t6_done", 64'(o_done), 64'd0);
        chk_res("t6", 0, 0, 0, 32'hFFFF_FFFF, 32'd0, 64'd0);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("t6_no_done", 64'(done_seen - d0), 64'd0);
        chk("t6_idle", 64'(o_busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end

endmodule
